dnn_train_sequencer: RTL and testbench
======================================

Name: dnn_train_sequencer

Overview:
Synthesizable training-run controller for the DNN block. Generates the block-cycle index, the per-clock input/output mux select and the training-case index that feed the DNN's input muxes. Scores each training case by comparing a_out against y_out over the output cycles, and keeps running case, error and epoch counts. Replaces the behavioural case sequencing and scoring currently done inside the MNIST bench so that on-chip training runs can be controlled and observed.

Parameters:
CPC, 130, clocks per block cycle (n[0]*fo[0]/z[0]+2); must be >= 3
TRAINING_CASES, 50000, cases per epoch; sel_tc wraps at this value
START_TC, 0, sel_tc value after reset
OUT_W, 1, output bits compared per clock (z[L-2]/fi[L-2])
MAX_CASES, 100000, cases to run before DONE; 0 = unlimited
CNT_W, 32, width of num_train/total_error/epoch counters
WIN, 100, recent-accuracy window depth (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; IDLE->RUN
stop  in  1  pulse; request halt at the next block boundary
a_out  in  OUT_W  DNN actual output bits
y_out  in  OUT_W  DNN ideal output bits
cycle_index  out  clog2(CPC)  position within block cycle
cycle_clk  out  1  one-clock pulse when cycle_index==0 while running
sel_network  out  clog2(CPC-2)  cycle_index-2, truncated
sel_tc  out  clog2(TRAINING_CASES)  current training case
tc_done  out  1  one-clock pulse: case scored
tc_error  out  1  valid with tc_done: case had a mismatch
epoch_done  out  1  one-clock pulse when sel_tc wraps
num_train  out  CNT_W  completed cases
total_error  out  CNT_W  erroneous cases
epoch  out  CNT_W  completed epochs
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE

Behaviour:
- Reset values: state IDLE; cycle_index 0; sel_tc START_TC; all counters 0; all pulses, busy and done 0. Reset mid-run aborts immediately, and no tc_done is emitted for the partial case.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: cycle_index is held at 0. start -> RUN, and cycle_index begins counting on the next edge.
- RUN: cycle_index runs 0..CPC-1 and wraps. stop -> DRAIN; the current block completes.
- DRAIN: same counting as RUN. At the CPC-1 -> 0 boundary go to IDLE with cycle_index 0.
- DONE: entered at the block boundary where num_train reaches MAX_CASES (MAX_CASES != 0). Counting freezes. Only reset leaves DONE. start is ignored.
- start in RUN/DRAIN/DONE is ignored. stop in IDLE/DONE is ignored. stop and the MAX_CASES limit on the same boundary -> DONE.
- cycle_clk = busy & (cycle_index==0), registered so it is aligned with cycle_index.
- sel_network = cycle_index-2 modulo 2^width. Its value during cycles 0 and 1 is don't-care for the DNN but must be deterministic.
- Scoring: on each edge with busy and cycle_index>=2, a mismatch (a_out!=y_out, any bit) sets err_acc.
- On the edge where cycle_index==CPC-1:
  - tc_error <= err_acc | current mismatch
  - tc_done <= 1
  - err_acc <= 0
  - num_train += 1
  - total_error += that error
  - sel_tc <= (sel_tc==TRAINING_CASES-1) ? 0 : sel_tc+1
  - on wrap: epoch += 1 and epoch_done <= 1
- Scoring outputs therefore appear 1 clock after the last output cycle, coincident with cycle_index==0 of the next block.
- Counters saturate at 2^CNT_W-1; they never wrap.

Optional Feature:
RECENT_WINDOW_EN. When defined, the block adds:
- a WIN-deep shift register of per-case correct flags, initialised to 0
- output recent_correct, width clog2(WIN+1), updated with tc_done: +1 for the new correct flag, -1 for the flag shifted out
- reset clears both the shift register and the count.
When undefined, the port and the logic are absent, and all other behaviour is identical.

Test Plan:
- CPC=6, TRAINING_CASES=4, MAX_CASES=0; start; a_out==y_out throughout -> cycle_clk every 6 clocks; tc_done every 6 clocks with tc_error=0; sel_tc sequence 0,1,2,3,0; epoch_done on the 4th tc_done; epoch=1; total_error=0.
- Force a_out!=y_out for one clock at cycle_index=3 of case 1 only -> that tc_done has tc_error=1; total_error=1; the following case has tc_error=0 (err_acc cleared).
- Mismatch only at cycle_index 0 or 1 -> tc_error=0. Mismatch only at cycle_index CPC-1 -> tc_error=1.
- MAX_CASES=3 -> done=1 after the 3rd tc_done; busy=0; cycle_index frozen at 0; a later start is ignored; num_train stays 3.
- stop at cycle_index=2 -> block completes, tc_done fires, state IDLE with cycle_index 0; start resumes at the next sel_tc with counters retained.
- reset asserted at cycle_index=4 mid-case -> all outputs return to reset values asynchronously and no tc_done is emitted. With RECENT_WINDOW_EN and WIN=4: outcome pattern 1,1,0,1,1 gives recent_correct 1,2,2,3,3.

Source files
------------

// File: rtl/dnn_train_sequencer.sv
// dnn_train_sequencer: training-run controller; clk/reset, start/stop, a_out/y_out in; cycle/case/scoring/counter outputs; optional RECENT_WINDOW_EN adds recent_correct
module dnn_train_sequencer #(
  parameter int CPC = 130,
  parameter int TRAINING_CASES = 50000,
  parameter int START_TC = 0,
  parameter int OUT_W = 1,
  parameter int MAX_CASES = 100000,
  parameter int CNT_W = 32,
  parameter int WIN = 100,
  localparam int CW = $clog2(CPC),
  localparam int SW = (CPC > 3) ? $clog2(CPC - 2) : 1,
  localparam int TW = (TRAINING_CASES > 1) ? $clog2(TRAINING_CASES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [OUT_W-1:0] a_out,
  input  logic [OUT_W-1:0] y_out,
  output logic [CW-1:0]    cycle_index,
  output logic             cycle_clk,
  output logic [SW-1:0]    sel_network,
  output logic [TW-1:0]    sel_tc,
  output logic             tc_done,
  output logic             tc_error,
  output logic             epoch_done,
  output logic [CNT_W-1:0] num_train,
  output logic [CNT_W-1:0] total_error,
  output logic [CNT_W-1:0] epoch,
  output logic             busy,
  output logic             done
`ifdef RECENT_WINDOW_EN
  , output logic [$clog2(WIN+1)-1:0] recent_correct
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] ci_n;
  logic [CNT_W-1:0] num_n;
  logic last, mm, err, wrap, busy_n, err_acc;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign sel_network = SW'(cycle_index - CW'(2));
  always_comb begin
    mm = a_out != y_out;
    last = busy && cycle_index == CW'(CPC - 1);
    err = err_acc | mm;
    wrap = sel_tc == TW'(TRAINING_CASES - 1);
    num_n = (num_train != '1) ? num_train + 1'b1 : num_train;
    ci_n = (busy && !last) ? cycle_index + 1'b1 : '0;
    // the case limit wins over a pending stop on the same boundary
    state_n = (state == IDLE && start) ? RUN
            : (last && MAX_CASES != 0 && num_n >= CNT_W'(MAX_CASES)) ? DONE
            : (last && (state == DRAIN || stop)) ? IDLE
            : (state == RUN && stop) ? DRAIN : state;
    busy_n = state_n == RUN || state_n == DRAIN;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cycle_index <= '0;
      cycle_clk <= 1'b0;
      sel_tc <= TW'(START_TC);
      err_acc <= 1'b0;
      tc_done <= 1'b0;
      tc_error <= 1'b0;
      epoch_done <= 1'b0;
      num_train <= '0;
      total_error <= '0;
      epoch <= '0;
    end else begin
      state <= state_n;
      cycle_index <= ci_n;
      cycle_clk <= busy_n && ci_n == '0;
      tc_done <= last;
      tc_error <= last && err;
      epoch_done <= last && wrap;
      // cycles 0 and 1 load inputs and are never scored
      err_acc <= !last && (err_acc || (busy && cycle_index >= CW'(2) && mm));
      if (last) begin
        num_train <= num_n;
        sel_tc <= wrap ? '0 : sel_tc + 1'b1;
        if (err && total_error != '1) total_error <= total_error + 1'b1;
        if (wrap && epoch != '1) epoch <= epoch + 1'b1;
      end
    end
  end
`ifdef RECENT_WINDOW_EN
  logic [WIN-1:0] hist;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      recent_correct <= '0;
    end else if (last) begin
      hist <= WIN'({hist, !err});
      recent_correct <= recent_correct + ($clog2(WIN+1))'(!err) - ($clog2(WIN+1))'(hist[WIN-1]);
    end
  end
`endif
endmodule

// File: tb/tb_dnn_train_sequencer.sv
// tb_dnn_train_sequencer: directed self-checking bench for dnn_train_sequencer
module tb_dnn_train_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, start2 = 1'b0, stop2 = 1'b0;
  logic [0:0] a_out = 1'b0, y_out = 1'b0;
  logic [2:0] ci, ci2;
  logic [1:0] sn, sn2, tc, tc2;
  logic cc, cc2, tcd, tcd2, tce, tce2, ed, ed2, bsy, bsy2, dn, dn2;
  logic [15:0] nt, nt2, te, te2, ep, ep2;
`ifdef RECENT_WINDOW_EN
  logic [2:0] rc, rc2;
`endif
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  dnn_train_sequencer #(.CPC(6), .TRAINING_CASES(4), .START_TC(0), .OUT_W(1), .MAX_CASES(0), .CNT_W(16), .WIN(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .a_out(a_out), .y_out(y_out),
    .cycle_index(ci), .cycle_clk(cc), .sel_network(sn), .sel_tc(tc), .tc_done(tcd), .tc_error(tce),
    .epoch_done(ed), .num_train(nt), .total_error(te), .epoch(ep), .busy(bsy), .done(dn)
`ifdef RECENT_WINDOW_EN
    , .recent_correct(rc)
`endif
  );
  dnn_train_sequencer #(.CPC(6), .TRAINING_CASES(4), .START_TC(0), .OUT_W(1), .MAX_CASES(3), .CNT_W(16), .WIN(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .stop(stop2), .a_out(a_out), .y_out(y_out),
    .cycle_index(ci2), .cycle_clk(cc2), .sel_network(sn2), .sel_tc(tc2), .tc_done(tcd2), .tc_error(tce2),
    .epoch_done(ed2), .num_train(nt2), .total_error(te2), .epoch(ep2), .busy(bsy2), .done(dn2)
`ifdef RECENT_WINDOW_EN
    , .recent_correct(rc2)
`endif
  );
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    tick(2);
    reset = 1'b0;
    chk("rst_ci", ci, 0); chk("rst_tc", tc, 0); chk("rst_nt", nt, 0); chk("rst_busy", bsy, 0);
    chk("rst_done", dn, 0); chk("rst_cc", cc, 0); chk("rst_tcd", tcd, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("run_busy", bsy, 1); chk("run_ci0", ci, 0); chk("run_cc0", cc, 1); chk("run_sn0", sn, 2);
    tick(1);
    chk("run_ci1", ci, 1); chk("run_cc1", cc, 0); chk("run_sn1", sn, 3);
    tick(5);
    chk("c0_tcd", tcd, 1); chk("c0_tce", tce, 0); chk("c0_tc", tc, 1); chk("c0_nt", nt, 1);
    chk("c0_ci", ci, 0); chk("c0_cc", cc, 1);
`ifdef RECENT_WINDOW_EN
    chk("c0_rc", rc, 1);
`endif
    tick(1);
    chk("c0_tcd_off", tcd, 0); chk("c0_cc_off", cc, 0);
    tick(2);
    chk("c1_ci3", ci, 3);
    a_out = 1'b1;
    tick(1);
    a_out = 1'b0;
    tick(2);
    chk("c1_tcd", tcd, 1); chk("c1_tce", tce, 1); chk("c1_te", te, 1); chk("c1_tc", tc, 2); chk("c1_nt", nt, 2);
`ifdef RECENT_WINDOW_EN
    chk("c1_rc", rc, 1);
`endif
    a_out = 1'b1;
    tick(2);
    a_out = 1'b0;
    tick(4);
    chk("c2_tcd", tcd, 1); chk("c2_tce", tce, 0); chk("c2_te", te, 1); chk("c2_tc", tc, 3); chk("c2_ed", ed, 0);
`ifdef RECENT_WINDOW_EN
    chk("c2_rc", rc, 2);
`endif
    tick(5);
    chk("c3_ci5", ci, 5);
    a_out = 1'b1;
    tick(1);
    a_out = 1'b0;
    chk("c3_tcd", tcd, 1); chk("c3_tce", tce, 1); chk("c3_te", te, 2); chk("c3_tc", tc, 0);
    chk("c3_ed", ed, 1); chk("c3_ep", ep, 1); chk("c3_nt", nt, 4);
`ifdef RECENT_WINDOW_EN
    chk("c3_rc", rc, 2);
`endif
    tick(1);
    chk("c3_ed_off", ed, 0);
    tick(1);
    chk("stop_ci2", ci, 2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("drain_busy", bsy, 1); chk("drain_ci", ci, 3);
    tick(3);
    chk("drain_tcd", tcd, 1); chk("drain_busy_off", bsy, 0); chk("drain_ci0", ci, 0);
    chk("drain_nt", nt, 5); chk("drain_tc", tc, 1); chk("drain_cc", cc, 0);
`ifdef RECENT_WINDOW_EN
    chk("drain_rc", rc, 2);
`endif
    tick(2);
    chk("idle_ci", ci, 0); chk("idle_busy", bsy, 0); chk("idle_tcd", tcd, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("resume_busy", bsy, 1); chk("resume_tc", tc, 1); chk("resume_nt", nt, 5); chk("resume_te", te, 2);
    tick(4);
    chk("pre_rst_ci", ci, 4);
    reset = 1'b1;
    #2;
    chk("arst_ci", ci, 0); chk("arst_busy", bsy, 0); chk("arst_nt", nt, 0); chk("arst_te", te, 0);
    chk("arst_ep", ep, 0); chk("arst_tc", tc, 0); chk("arst_cc", cc, 0);
`ifdef RECENT_WINDOW_EN
    chk("arst_rc", rc, 0);
`endif
    tick(2);
    chk("arst_tcd", tcd, 0);
    reset = 1'b0;
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    chk("max_busy", bsy2, 1);
    tick(6);
    chk("max_nt1", nt2, 1); chk("max_busy1", bsy2, 1); chk("max_done1", dn2, 0);
    tick(12);
    chk("max_tcd", tcd2, 1); chk("max_nt3", nt2, 3); chk("max_done", dn2, 1); chk("max_busy_off", bsy2, 0); chk("max_ci", ci2, 0);
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    tick(7);
    chk("max_hold_done", dn2, 1); chk("max_hold_busy", bsy2, 0); chk("max_hold_ci", ci2, 0);
    chk("max_hold_nt", nt2, 3); chk("max_hold_cc", cc2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
